deparser_do_deparsing: RTL and testbench



---
 rtl/deparser_do_deparsing_if.sv | 34 +++
 rtl/deparser_do_deparsing.sv | 168 ++++++++++++++++
 tb/tb_deparser_do_deparsing.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deparser_do_deparsing_if.sv
// Bus bundle between the deparser and its neighbours: PHV and header segments in,
// the per-VLAN action word in, rebuilt segments plus PHV metadata out.
interface deparser_do_deparsing_if #(
  parameter int C_AXIS_DATA_WIDTH      = 256,
  parameter int C_AXIS_TUSER_WIDTH     = 128,
  parameter int C_NUM_SEGS             = 16,
  parameter int PKT_HDR_LEN            = 4*8*64+256,
  parameter int C_VLANID_WIDTH         = 12,
  parameter int C_NUM_DEPARSE_ACTION   = 64,
  parameter int C_WIDTH_DEPARSE_ACTION = 16
);
  logic [PKT_HDR_LEN-1:0]                                 phv_in;
  logic                                                   phv_valid_in;
  logic                                                   phv_ready_out;
  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]                tdata_segs_in;
  logic                                                   segs_valid_in;
  logic                                                   segs_ready_out;
  logic [C_NUM_DEPARSE_ACTION*C_WIDTH_DEPARSE_ACTION-1:0] bram_out;
  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]                tdata_segs_out;
  logic [C_AXIS_TUSER_WIDTH-1:0]                          tuser_out;
  logic [C_VLANID_WIDTH-1:0]                              vlan_out;
  logic                                                   segs_valid_out;
  logic                                                   segs_ready_in;

  modport slave (
    input  phv_in, phv_valid_in, tdata_segs_in, segs_valid_in, bram_out, segs_ready_in,
    output phv_ready_out, segs_ready_out, tdata_segs_out, tuser_out, vlan_out, segs_valid_out
  );

  modport master (
    output phv_in, phv_valid_in, tdata_segs_in, segs_valid_in, bram_out, segs_ready_in,
    input  phv_ready_out, segs_ready_out, tdata_segs_out, tuser_out, vlan_out, segs_valid_out
  );
endinterface

// File: rtl/deparser_do_deparsing.sv
// Writes PHV 4-byte containers back into the captured header segments, one action per
// cycle, then presents the rebuilt segments with tuser/VLAN until downstream accepts.
module deparser_do_deparsing #(
  parameter int C_AXIS_DATA_WIDTH      = 256,
  parameter int C_AXIS_TUSER_WIDTH     = 128,
  parameter int C_NUM_SEGS             = 16,
  parameter int PKT_HDR_LEN            = 4*8*64+256,
  parameter int C_VLANID_WIDTH         = 12,
  parameter int C_NUM_DEPARSE_ACTION   = 64,
  parameter int C_WIDTH_DEPARSE_ACTION = 16
) (
  input logic                    axis_clk,
  input logic                    aresetn,
  deparser_do_deparsing_if.slave bus
);
  localparam int SEGS_W    = C_NUM_SEGS*C_AXIS_DATA_WIDTH;
  localparam int SEG_BYTES = SEGS_W/8;
  localparam int CONT_BASE = 256;
  localparam int CONT_W    = PKT_HDR_LEN-CONT_BASE;
  localparam int VLAN_LSB  = 129;
  localparam int OFF_W     = C_WIDTH_DEPARSE_ACTION-7;
  localparam int CNT_W     = $clog2(C_NUM_DEPARSE_ACTION);
  localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(C_NUM_DEPARSE_ACTION-1);

  typedef enum logic [1:0] {IDLE, DEPARSE, OUTPUT} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          phv_cap_q, phv_cap_d;
  logic                          segs_cap_q, segs_cap_d;
  logic                          phv_rdy_q, phv_rdy_d;
  logic                          segs_rdy_q, segs_rdy_d;
  logic [CONT_W-1:0]             cont_q, cont_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_cap_q, tuser_cap_d;
  logic [C_VLANID_WIDTH-1:0]     vlan_cap_q, vlan_cap_d;
  logic [SEGS_W-1:0]             buf_q, buf_d;
  logic [SEGS_W-1:0]             segs_out_q, segs_out_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_out_q, tuser_out_d;
  logic [C_VLANID_WIDTH-1:0]     vlan_out_q, vlan_out_d;
  logic                          valid_q, valid_d;

  logic                              phv_hs, segs_hs;
  logic [C_WIDTH_DEPARSE_ACTION-1:0] act;
  logic [OFF_W-1:0]                  act_off;
  logic [5:0]                        act_idx;
  logic [31:0]                       act_cont;
  int                                off_i;

  // Bit 128 and the gap between VLAN and the containers carry nothing we re-emit.
  logic unused_phv;
  assign unused_phv = &{1'b0, bus.phv_in[CONT_BASE-1:VLAN_LSB+C_VLANID_WIDTH],
                        bus.phv_in[C_AXIS_TUSER_WIDTH]};

  assign phv_hs  = bus.phv_valid_in & phv_rdy_q;
  assign segs_hs = bus.segs_valid_in & segs_rdy_q;

  assign act      = bus.bram_out[(C_NUM_DEPARSE_ACTION-1-int'(cnt_q))*C_WIDTH_DEPARSE_ACTION
                                 +: C_WIDTH_DEPARSE_ACTION];
  assign act_off  = act[C_WIDTH_DEPARSE_ACTION-2:6];
  assign act_idx  = act[5:0];
  assign act_cont = cont_q[32*int'(act_idx) +: 32];
  assign off_i    = int'(act_off);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phv_cap_d   = phv_cap_q;
    segs_cap_d  = segs_cap_q;
    cont_d      = cont_q;
    tuser_cap_d = tuser_cap_q;
    vlan_cap_d  = vlan_cap_q;
    buf_d       = buf_q;
    segs_out_d  = segs_out_q;
    tuser_out_d = tuser_out_q;
    vlan_out_d  = vlan_out_q;
    valid_d     = valid_q;

    case (state_q)
      IDLE: begin
        if (phv_hs) begin
          cont_d      = bus.phv_in[CONT_BASE +: CONT_W];
          tuser_cap_d = bus.phv_in[0 +: C_AXIS_TUSER_WIDTH];
          vlan_cap_d  = bus.phv_in[VLAN_LSB +: C_VLANID_WIDTH];
          phv_cap_d   = 1'b1;
        end
        if (segs_hs) begin
          buf_d      = bus.tdata_segs_in;
          segs_cap_d = 1'b1;
        end
        if (phv_cap_d && segs_cap_d) begin
          state_d = DEPARSE;
          cnt_d   = '0;
        end
      end
      DEPARSE: begin
        // Container bytes go back in network order, undoing the parser's byte swap.
        if (act[C_WIDTH_DEPARSE_ACTION-1] && (off_i + 4 <= SEG_BYTES)) begin
          for (int j = 0; j < 4; j++) begin
            buf_d[8*(off_i+j) +: 8] = act_cont[8*(3-j) +: 8];
          end
        end
        if (cnt_q == LAST_ACT) begin
          state_d     = OUTPUT;
          segs_out_d  = buf_d;
          tuser_out_d = tuser_cap_q;
          vlan_out_d  = vlan_cap_q;
          valid_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (valid_q && bus.segs_ready_in) begin
          valid_d    = 1'b0;
          phv_cap_d  = 1'b0;
          segs_cap_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Readies are registered from next state so they stay low for a cycle after reset.
    phv_rdy_d  = (state_d == IDLE) && !phv_cap_d;
    segs_rdy_d = (state_d == IDLE) && !segs_cap_d;
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phv_cap_q   <= 1'b0;
      segs_cap_q  <= 1'b0;
      phv_rdy_q   <= 1'b0;
      segs_rdy_q  <= 1'b0;
      cont_q      <= '0;
      tuser_cap_q <= '0;
      vlan_cap_q  <= '0;
      buf_q       <= '0;
      segs_out_q  <= '0;
      tuser_out_q <= '0;
      vlan_out_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phv_cap_q   <= phv_cap_d;
      segs_cap_q  <= segs_cap_d;
      phv_rdy_q   <= phv_rdy_d;
      segs_rdy_q  <= segs_rdy_d;
      cont_q      <= cont_d;
      tuser_cap_q <= tuser_cap_d;
      vlan_cap_q  <= vlan_cap_d;
      buf_q       <= buf_d;
      segs_out_q  <= segs_out_d;
      tuser_out_q <= tuser_out_d;
      vlan_out_q  <= vlan_out_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.phv_ready_out  = phv_rdy_q;
  assign bus.segs_ready_out = segs_rdy_q;
  assign bus.tdata_segs_out = segs_out_q;
  assign bus.tuser_out      = tuser_out_q;
  assign bus.vlan_out       = vlan_out_q;
  assign bus.segs_valid_out = valid_q;
endmodule

// File: tb/tb_deparser_do_deparsing.sv
// Randomized bench for the deparser: a byte-array reference model predicts every output
// packet, and a negedge compare process checks each valid output cycle against it.
module tb_deparser_do_deparsing;
  localparam int DW = 256, TW = 128, NS = 16, PW = 4*8*64+256, VW = 12, NA = 64, AW = 16;
  localparam int SW = NS*DW, NB = SW/8, BW = NA*AW;

  typedef logic [SW-1:0] segs_t;
  typedef logic [PW-1:0] phv_t;
  typedef logic [BW-1:0] bram_t;
  typedef struct packed {
    segs_t          segs;
    logic [TW-1:0]  tuser;
    logic [VW-1:0]  vlan;
  } exp_t;

  logic axis_clk = 1'b0;
  logic aresetn  = 1'b0;
  always #5 axis_clk = ~axis_clk;

  deparser_do_deparsing_if #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW), .C_NUM_SEGS(NS), .PKT_HDR_LEN(PW),
    .C_VLANID_WIDTH(VW), .C_NUM_DEPARSE_ACTION(NA), .C_WIDTH_DEPARSE_ACTION(AW)
  ) bus_if ();

  deparser_do_deparsing #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW), .C_NUM_SEGS(NS), .PKT_HDR_LEN(PW),
    .C_VLANID_WIDTH(VW), .C_NUM_DEPARSE_ACTION(NA), .C_WIDTH_DEPARSE_ACTION(AW)
  ) dut (
    .axis_clk(axis_clk),
    .aresetn (aresetn),
    .bus     (bus_if)
  );

  int    errors = 0;
  int    checks = 0;
  int    xfers  = 0;
  int    cyc    = 0;
  exp_t  exp_q[$];
  segs_t last_out;

  always @(posedge axis_clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endfunction

  // Reference: treat the header as a 512-byte array and apply the valid, in-range
  // actions in index order, container bytes most-significant first.
  function automatic segs_t model(input phv_t p, input segs_t s, input bram_t b);
    logic [7:0]  bytes [NB];
    logic [15:0] a;
    logic [31:0] c;
    int          off;
    segs_t       r;
    for (int i = 0; i < NB; i++) bytes[i] = s[8*i +: 8];
    for (int k = 0; k < NA; k++) begin
      a   = b[(NA-1-k)*AW +: AW];
      off = int'(a[14:6]);
      if (a[15] && off + 4 <= NB) begin
        c = p[256 + 32*int'(a[5:0]) +: 32];
        bytes[off]   = c[31:24];
        bytes[off+1] = c[23:16];
        bytes[off+2] = c[15:8];
        bytes[off+3] = c[7:0];
      end
    end
    for (int i = 0; i < NB; i++) r[8*i +: 8] = bytes[i];
    return r;
  endfunction

  function automatic int byte_diff(input segs_t a, input segs_t b);
    for (int i = 0; i < NB; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
    return -1;
  endfunction

  function automatic void chk_segs(input string name, input segs_t got, input segs_t want);
    int d;
    d = byte_diff(got, want);
    if (d < 0) chk(1'b1, name, "", "");
    else chk(1'b0, name, $sformatf("byte %0d = %02h", d, got[8*d +: 8]),
             $sformatf("%02h", want[8*d +: 8]));
  endfunction

  function automatic phv_t rand_phv();
    phv_t v;
    for (int i = 0; i < PW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic segs_t rand_segs();
    segs_t v;
    for (int i = 0; i < SW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic bram_t rand_bram();
    bram_t v;
    for (int i = 0; i < BW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic bram_t set_act(input bram_t b, input int k, input int off, input int idx);
    bram_t r;
    r = b;
    r[(NA-1-k)*AW +: AW] = {1'b1, 9'(off), 6'(idx)};
    return r;
  endfunction

  // Compare process: every valid output cycle must match the oldest expected packet.
  always @(negedge axis_clk) begin
    if (aresetn && bus_if.segs_valid_out) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_valid", "segs_valid_out=1", "no packet pending");
      end else begin
        chk_segs("segs_out", bus_if.tdata_segs_out, exp_q[0].segs);
        chk(bus_if.tuser_out === exp_q[0].tuser, "tuser_out",
            $sformatf("%h", bus_if.tuser_out), $sformatf("%h", exp_q[0].tuser));
        chk(bus_if.vlan_out === exp_q[0].vlan, "vlan_out",
            $sformatf("%h", bus_if.vlan_out), $sformatf("%h", exp_q[0].vlan));
        chk(!bus_if.phv_ready_out && !bus_if.segs_ready_out, "ready_in_output",
            $sformatf("%b%b", bus_if.phv_ready_out, bus_if.segs_ready_out), "00");
        if (bus_if.segs_ready_in) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic run_pkt(input phv_t p, input segs_t s, input bram_t b,
                         input int dp, input int ds, input int stall, input bit abort);
    int t_phv, t_segs, t2, n, x0;
    exp_t e;
    bus_if.segs_ready_in = (stall == 0);
    bus_if.bram_out      = b;
    if (!abort) begin
      e.segs  = model(p, s, b);
      e.tuser = p[127:0];
      e.vlan  = p[140:129];
      exp_q.push_back(e);
    end
    fork
      begin : phv_branch
        int m;
        bit hs;
        repeat (dp) begin @(posedge axis_clk); #1; end
        bus_if.phv_in = p;
        bus_if.phv_valid_in = 1'b1;
        m = 0;
        do begin
          @(posedge axis_clk);
          hs = bus_if.phv_valid_in && bus_if.phv_ready_out;
          m++;
        end while (!hs && m < 200);
        t_phv = cyc;
        #1 bus_if.phv_valid_in = 1'b0;
        chk(hs, "phv_handshake", "timeout", "accept");
        chk(!bus_if.phv_ready_out, "phv_ready_after_capture", "1", "0");
      end
      begin : segs_branch
        int m;
        bit hs;
        repeat (ds) begin @(posedge axis_clk); #1; end
        bus_if.tdata_segs_in = s;
        bus_if.segs_valid_in = 1'b1;
        m = 0;
        do begin
          @(posedge axis_clk);
          hs = bus_if.segs_valid_in && bus_if.segs_ready_out;
          m++;
        end while (!hs && m < 200);
        t_segs = cyc;
        #1 bus_if.segs_valid_in = 1'b0;
        chk(hs, "segs_handshake", "timeout", "accept");
        chk(!bus_if.segs_ready_out, "segs_ready_after_capture", "1", "0");
      end
    join
    t2 = (t_phv > t_segs) ? t_phv : t_segs;

    if (abort) begin
      repeat (20) @(posedge axis_clk);
      #1 aresetn = 1'b0;
      @(posedge axis_clk);
      #1 aresetn = 1'b1;
      chk(!bus_if.segs_valid_out && !bus_if.phv_ready_out && !bus_if.segs_ready_out,
          "abort_ctrl_zero", $sformatf("%b%b%b", bus_if.segs_valid_out, bus_if.phv_ready_out,
          bus_if.segs_ready_out), "000");
      chk_segs("abort_segs_zero", bus_if.tdata_segs_out, '0);
      chk(bus_if.tuser_out === '0 && bus_if.vlan_out === '0, "abort_meta_zero",
          $sformatf("%h/%h", bus_if.tuser_out, bus_if.vlan_out), "0/0");
      return;
    end

    n = 0;
    do begin @(posedge axis_clk); #1; n++; end while (!bus_if.segs_valid_out && n < 300);
    chk(bus_if.segs_valid_out, "valid_timeout", "0", "1");
    chk(cyc - t2 == NA + 1, "latency", $sformatf("%0d", cyc - t2), $sformatf("%0d", NA + 1));
    last_out = bus_if.tdata_segs_out;
    x0 = xfers;
    if (stall > 0) begin
      repeat (stall) begin @(posedge axis_clk); #1; end
      chk(bus_if.segs_valid_out && xfers == x0, "stall_hold",
          $sformatf("valid=%b xfers=%0d", bus_if.segs_valid_out, xfers - x0), "valid=1 xfers=0");
      bus_if.segs_ready_in = 1'b1;
    end
    n = 0;
    do begin @(posedge axis_clk); #1; n++; end while (bus_if.segs_valid_out && n < 50);
    chk(!bus_if.segs_valid_out, "xfer_timeout", "1", "0");
    @(posedge axis_clk); #1;
    chk(xfers == x0 + 1, "one_xfer", $sformatf("%0d", xfers - x0), "1");
    chk(exp_q.size() == 0, "queue_drained", $sformatf("%0d", exp_q.size()), "0");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    phv_t  p;
    segs_t s, want;
    bram_t b;

    bus_if.phv_in        = '0;
    bus_if.phv_valid_in  = 1'b0;
    bus_if.tdata_segs_in = '0;
    bus_if.segs_valid_in = 1'b0;
    bus_if.bram_out      = '0;
    bus_if.segs_ready_in = 1'b1;

    repeat (3) @(posedge axis_clk);
    #1;
    chk(!bus_if.segs_valid_out && !bus_if.phv_ready_out && !bus_if.segs_ready_out,
        "reset_ctrl", $sformatf("%b%b%b", bus_if.segs_valid_out, bus_if.phv_ready_out,
        bus_if.segs_ready_out), "000");
    chk_segs("reset_segs", bus_if.tdata_segs_out, '0);
    chk(bus_if.tuser_out === '0 && bus_if.vlan_out === '0, "reset_meta",
        $sformatf("%h/%h", bus_if.tuser_out, bus_if.vlan_out), "0/0");
    aresetn = 1'b1;
    @(posedge axis_clk); #1;

    // Single action writes C0.A8.00.01 at bytes 14..17.
    p = rand_phv();
    p[256 + 32*3 +: 32] = 32'hC0A80001;
    s = rand_segs();
    b = set_act('0, 0, 14, 3);
    run_pkt(p, s, b, 0, 0, 0, 1'b0);
    want = s;
    want[8*14 +: 8] = 8'hC0;
    want[8*15 +: 8] = 8'hA8;
    want[8*16 +: 8] = 8'h00;
    want[8*17 +: 8] = 8'h01;
    chk_segs("t1_literal", last_out, want);

    // PHV five cycles ahead of the segments.
    run_pkt(rand_phv(), rand_segs(), rand_bram(), 0, 5, 0, 1'b0);

    // Overlap: action 9 overrides action 2.
    p = rand_phv();
    p[256 + 32*1 +: 32] = 32'h11111111;
    p[256 + 32*2 +: 32] = 32'h22222222;
    s = rand_segs();
    b = set_act(set_act('0, 2, 30, 1), 9, 30, 2);
    run_pkt(p, s, b, 2, 0, 0, 1'b0);
    want = s;
    want[8*30 +: 32] = 32'h22222222;
    chk_segs("t3_overlap", last_out, want);

    // Out-of-range offset leaves the header untouched.
    s = rand_segs();
    run_pkt(rand_phv(), s, set_act('0, 0, 509, 5), 0, 0, 0, 1'b0);
    chk_segs("t4_skip", last_out, s);

    // Downstream stall.
    run_pkt(rand_phv(), rand_segs(), rand_bram(), 1, 1, 10, 1'b0);

    // Reset mid-deparse, then a clean packet.
    run_pkt(rand_phv(), rand_segs(), rand_bram(), 0, 0, 0, 1'b1);
    @(posedge axis_clk); #1;
    run_pkt(rand_phv(), rand_segs(), rand_bram(), 3, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_pkt(rand_phv(), rand_segs(), rand_bram(), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
